// File: rtl/ysyx_22050612_pkg.sv
// Shared constants and the fetch-queue entry type for the ysyx_22050612 core.
package ysyx_22050612_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ysyx_22050612_ifq_ptr.sv
// Queue pointer with an extra wrap bit; increments modulo 2*2^AW and clears synchronously.
module ysyx_22050612_ifq_ptr #(
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [AW:0] ptr_reg
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (clr) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050612_ifq.sv
// Instruction fetch queue between fetch and decode, with single-cycle flush.
// Define YSYX_22050612_IFQ_BYPASS_EN to pass fetch straight to decode when empty.
module ysyx_22050612_ifq #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = ysyx_22050612_pkg::PC_W,
    parameter int INST_W = ysyx_22050612_pkg::INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    import ysyx_22050612_pkg::*;

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [AW:0]   head_reg;
    logic [AW:0]   tail_reg;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    entry_t        mem_q [DEPTH];
    entry_t        head_entry;

    assign head_idx   = head_reg[AW-1:0];
    assign tail_idx   = tail_reg[AW-1:0];
    assign empty      = (head_reg == tail_reg);
    assign full       = (head_idx == tail_idx) && (head_reg[AW] != tail_reg[AW]);
    assign count      = tail_reg - head_reg;
    assign in_ready   = !full && !flush;
    assign head_entry = mem_q[head_idx];
    assign pop        = !empty && out_ready && !flush;

`ifdef YSYX_22050612_IFQ_BYPASS_EN
    logic bypass_sel;
    logic bypass_take;

    // An empty queue forwards fetch directly; a consumed forward never occupies a slot.
    assign bypass_sel  = empty && !flush;
    assign bypass_take = bypass_sel && in_valid && out_ready;
    assign out_valid   = bypass_sel ? in_valid : !empty;
    assign out_pc      = bypass_sel ? in_pc    : head_entry.pc;
    assign out_inst    = bypass_sel ? in_inst  : head_entry.inst;
    assign push        = in_valid && in_ready && !bypass_take;
`else
    assign out_valid   = !empty;
    assign out_pc      = head_entry.pc;
    assign out_inst    = head_entry.inst;
    assign push        = in_valid && in_ready;
`endif

    ysyx_22050612_ifq_ptr #(.AW(AW)) u_head (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .inc     (pop),
        .ptr_reg (head_reg)
    );

    ysyx_22050612_ifq_ptr #(.AW(AW)) u_tail (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .inc     (push),
        .ptr_reg (tail_reg)
    );

    // Storage survives a flush; only reset zeroes it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        entry_t entry_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg <= '0;
            end else if (push && (tail_idx == AW'(gi))) begin
                entry_reg <= {in_pc, in_inst};
            end
        end

        assign mem_q[gi] = entry_reg;
    end

endmodule
